// File: rtl/exhaustive_vector_sequencer_if.sv
// Record stream carrying (vector, response) pairs from the sweep sequencer to its consumer.
interface exhaustive_vector_sequencer_if #(
  parameter int unsigned N_IN = 6
);
  logic            rec_valid;
  logic            rec_ready;
  logic [N_IN-1:0] rec_vec;
  logic            rec_resp;

  modport master (output rec_valid, output rec_vec, output rec_resp, input rec_ready);
  modport slave  (input rec_valid, input rec_vec, input rec_resp, output rec_ready);
endinterface

// File: rtl/exhaustive_vector_sequencer.sv
// Sweeps all 2^N_IN vectors into a combinational block, emitting one (vector, response) record each.
// Optional MISR signature compaction is enabled by defining EXVS_MISR_EN.
module exhaustive_vector_sequencer #(
  parameter int unsigned N_IN   = 6,
  parameter int unsigned SETTLE = 1
) (
  input  logic                             CK,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  output logic [N_IN-1:0]                  vec_out,
  input  logic                             dut_out,
  exhaustive_vector_sequencer_if.master    rec,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      signature
);

  localparam int unsigned CNT_W = 8;
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_EMIT, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rec_valid_q, rec_valid_d;
  logic [N_IN-1:0]   rec_vec_q, rec_vec_d;
  logic              rec_resp_q, rec_resp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef EXVS_MISR_EN
  logic [15:0]       sig_q, sig_d;
  logic              fb;
  assign fb = sig_q[15] ^ rec_resp_q;
`endif

  // Next-state and next-output logic; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rec_valid_d = rec_valid_q;
    rec_vec_d   = rec_vec_q;
    rec_resp_d  = rec_resp_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef EXVS_MISR_EN
    sig_d       = sig_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          idx_d   = '0;
          cnt_d   = CNT_W'(SETTLE);
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef EXVS_MISR_EN
          sig_d   = 16'h0000;
`endif
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rec_vec_d   = idx_q;
          rec_resp_d  = dut_out;
          rec_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
`ifdef EXVS_MISR_EN
          sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
`endif
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + N_IN'(1);
            cnt_d   = CNT_W'(SETTLE);
            state_d = ST_SETTLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      rec_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
`ifdef EXVS_MISR_EN
      sig_d       = sig_q;
`endif
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rec_valid_q <= 1'b0;
      rec_vec_q   <= '0;
      rec_resp_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rec_valid_q <= rec_valid_d;
      rec_vec_q   <= rec_vec_d;
      rec_resp_q  <= rec_resp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef EXVS_MISR_EN
  always_ff @(posedge CK or posedge reset) begin
    if (reset) sig_q <= 16'h0000;
    else       sig_q <= sig_d;
  end
  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

  assign vec_out       = idx_q;
  assign rec.rec_valid = rec_valid_q;
  assign rec.rec_vec   = rec_vec_q;
  assign rec.rec_resp  = rec_resp_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Scoreboard bench: sweeps push expected records, a negedge monitor pops and compares on each handshake.
module tb_exhaustive_vector_sequencer;

  localparam int unsigned N_IN = 6;

`ifdef EXVS_MISR_EN
  localparam logic [15:0] SIG_AND = 16'h1021;
`else
  localparam logic [15:0] SIG_AND = 16'h0000;
`endif

  typedef struct packed {
    logic [N_IN-1:0] vec;
    logic            resp;
  } rec_t;

  logic            CK, reset, start, abort, dut_out, busy, done;
  logic [N_IN-1:0] vec_out;
  logic [15:0]     signature;
  int              mode;

  logic            start3, abort3, busy3, done3;
  logic [N_IN-1:0] vec3;
  logic [15:0]     sig3;

  exhaustive_vector_sequencer_if #(.N_IN(N_IN)) rec_if ();
  exhaustive_vector_sequencer_if #(.N_IN(N_IN)) rec_if3 ();

  exhaustive_vector_sequencer #(.N_IN(N_IN), .SETTLE(1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .vec_out(vec_out),
    .dut_out(dut_out), .rec(rec_if), .busy(busy), .done(done), .signature(signature));

  exhaustive_vector_sequencer #(.N_IN(N_IN), .SETTLE(3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .abort(abort3), .vec_out(vec3),
    .dut_out(vec3[0]), .rec(rec_if3), .busy(busy3), .done(done3), .signature(sig3));

  assign dut_out = (mode == 0) ? vec_out[0] : (mode == 1) ? (&vec_out) : 1'b0;
  assign rec_if3.rec_ready = 1'b1;
  assign abort3 = 1'b0;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-derived response for vector v under each dut_out pattern.
  task automatic push_sweep(input int m, input int n);
    rec_t r;
    for (int v = 0; v < n; v++) begin
      r.vec  = N_IN'(v);
      r.resp = (m == 0) ? r.vec[0] : (m == 1) ? (v == 63) : 1'b0;
      exp_q.push_back(r);
    end
  endtask

  task automatic pulse_start;
    @(posedge CK); #1 start = 1'b1;
    @(posedge CK); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(posedge CK); #1;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  always @(negedge CK) begin
    if (!reset && rec_if.rec_valid && rec_if.rec_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 32'(rec_if.rec_vec), 32'hFFFF_FFFF);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("rec_vec", 32'(rec_if.rec_vec), 32'(e.vec));
        check("rec_resp", 32'(rec_if.rec_resp), 32'(e.resp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0;
    rec_if.rec_ready = 1'b1; mode = 0;
    @(negedge CK);
    check("reset_vec_out", 32'(vec_out), 32'd0);
    check("reset_rec_valid", 32'(rec_if.rec_valid), 32'd0);
    check("reset_rec_vec", 32'(rec_if.rec_vec), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_signature", 32'(signature), 32'd0);
    @(posedge CK); #1 reset = 1'b0;

    // Full sweep with a start re-pulse while busy.
    mode = 0; push_sweep(0, 64);
    pulse_start;
    check("e0_busy", 32'(busy), 32'd1);
    check("e0_rec_valid", 32'(rec_if.rec_valid), 32'd0);
    @(posedge CK); #1;
    check("first_rec_valid", 32'(rec_if.rec_valid), 32'd1);
    check("first_rec_vec", 32'(rec_if.rec_vec), 32'd0);
    repeat (40) @(posedge CK);
    #1 start = 1'b1;
    @(posedge CK); #1 start = 1'b0;
    check("busy_after_restart_pulse", 32'(busy), 32'd1);
    repeat (85) @(posedge CK);
    #1;
    check("done_before_128", 32'(done), 32'd0);
    @(posedge CK); #1;
    check("done_at_128", 32'(done), 32'd1);
    check("busy_at_128", 32'(busy), 32'd0);
    check("vec_out_held", 32'(vec_out), 32'd63);
    check("sweep1_records_left", 32'(exp_q.size()), 32'd0);

    // Backpressure on vector 3.
    push_sweep(0, 64);
    pulse_start;
    for (int i = 0; i < 50; i++) begin
      if (rec_if.rec_valid && rec_if.rec_vec == N_IN'(3)) break;
      @(posedge CK); #1;
    end
    rec_if.rec_ready = 1'b0;
    check("bp_reached_vec3", 32'(rec_if.rec_vec), 32'd3);
    repeat (5) begin
      @(negedge CK);
      check("bp_rec_valid", 32'(rec_if.rec_valid), 32'd1);
      check("bp_rec_vec", 32'(rec_if.rec_vec), 32'd3);
      check("bp_rec_resp", 32'(rec_if.rec_resp), 32'd1);
      check("bp_vec_out", 32'(vec_out), 32'd3);
    end
    @(posedge CK); #1 rec_if.rec_ready = 1'b1;
    check("bp_vec_out_before_hs", 32'(vec_out), 32'd3);
    @(posedge CK); #1;
    check("bp_vec_out_after_hs", 32'(vec_out), 32'd4);
    check("bp_valid_after_hs", 32'(rec_if.rec_valid), 32'd0);
    wait_done(300);
    check("bp_records_left", 32'(exp_q.size()), 32'd0);

    // Abort during SETTLE of vector 20.
    push_sweep(0, 20);
    pulse_start;
    for (int i = 0; i < 100; i++) begin
      if (vec_out == N_IN'(20)) break;
      @(posedge CK); #1;
    end
    check("abort_at_vec20", 32'(vec_out), 32'd20);
    check("abort_in_settle", 32'(rec_if.rec_valid), 32'd0);
    abort = 1'b1;
    @(posedge CK); #1 abort = 1'b0;
    check("abort_vec_out", 32'(vec_out), 32'd0);
    check("abort_rec_valid", 32'(rec_if.rec_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge CK);
    #1 check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_records_left", 32'(exp_q.size()), 32'd0);

    // Restart after abort, response = AND of all inputs.
    mode = 1; push_sweep(1, 64);
    pulse_start;
    check("restart_vec_out", 32'(vec_out), 32'd0);
    wait_done(200);
    check("and_signature", 32'(signature), 32'(SIG_AND));
    check("and_records_left", 32'(exp_q.size()), 32'd0);

    // Constant-zero response; signature must be cleared on start.
    mode = 2; push_sweep(2, 64);
    pulse_start;
    wait_done(200);
    check("zero_signature", 32'(signature), 32'd0);

    // Asynchronous reset while a record is pending.
    mode = 0; push_sweep(0, 64);
    pulse_start;
    for (int i = 0; i < 20; i++) begin
      if (rec_if.rec_valid) break;
      @(posedge CK); #1;
    end
    check("rst_pending_valid", 32'(rec_if.rec_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rst_async_rec_valid", 32'(rec_if.rec_valid), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_vec_out", 32'(vec_out), 32'd0);
    check("rst_async_signature", 32'(signature), 32'd0);
    exp_q.delete();
    @(posedge CK); #1 reset = 1'b0;

    // SETTLE=3 instance: latency, full sweep and restart from DONE.
    @(posedge CK); #1 start3 = 1'b1;
    @(posedge CK); #1 start3 = 1'b0;
    @(posedge CK); #1 check("s3_valid_e1", 32'(rec_if3.rec_valid), 32'd0);
    @(posedge CK); #1 check("s3_valid_e2", 32'(rec_if3.rec_valid), 32'd0);
    @(posedge CK); #1 check("s3_valid_e3", 32'(rec_if3.rec_valid), 32'd1);
    repeat (252) @(posedge CK);
    #1 check("s3_done_before_256", 32'(done3), 32'd0);
    @(posedge CK); #1;
    check("s3_done_at_256", 32'(done3), 32'd1);
    check("s3_busy_at_256", 32'(busy3), 32'd0);
    start3 = 1'b1;
    @(posedge CK); #1 start3 = 1'b0;
    check("s3_restart_done_falls", 32'(done3), 32'd0);
    check("s3_restart_busy", 32'(busy3), 32'd1);
    @(posedge CK);
    @(posedge CK); #1 check("s3_restart_valid_e2", 32'(rec_if3.rec_valid), 32'd0);
    @(posedge CK); #1 check("s3_restart_valid_e3", 32'(rec_if3.rec_valid), 32'd1);
    repeat (252) @(posedge CK);
    #1 check("s3_restart_done_before_256", 32'(done3), 32'd0);
    @(posedge CK); #1 check("s3_restart_done_at_256", 32'(done3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
